exec_sequencer: RTL and testbench

EXEC_SEQUENCER -- requirements
Module: exec_sequencer

---
 rtl/exec_sequencer.sv | 135 +++++++++++++
 tb/tb_exec_sequencer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/exec_sequencer.sv
// rtl/exec_sequencer.sv - multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer with 8x32 register file
module exec_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    output logic [31:0] alu_ip_0,
    output logic [31:0] alu_ip_1,
    output logic [2:0]  alu_opcode,
    input  logic [31:0] alu_op_0,
    input  logic        alu_change_pc,
    output logic        retire,
    output logic        halted
);

    typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, WRITEBACK, HALT} state_t;

    localparam logic [2:0] OP_HALT = 3'd1;
    localparam logic [2:0] OP_BEQ  = 3'd2;
    localparam logic [2:0] OP_BLT  = 3'd3;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] r_q, r_d;
    logic        t_q, t_d;
    logic [31:0] rf_q [8];
    logic        rf_we;

    logic [2:0]  opcode, rd, rs1, rs2;
    logic [31:0] offset_sext;
    logic        unused_ir;

    assign opcode      = ir_q[31:29];
    assign rd          = ir_q[28:26];
    assign rs1         = ir_q[25:23];
    assign rs2         = ir_q[22:20];
    assign offset_sext = {{16{ir_q[15]}}, ir_q[15:0]};
    assign unused_ir   = ^ir_q[19:16];

    assign imem_addr = pc_q;
    assign alu_ip_0  = a_q;
    assign alu_ip_1  = b_q;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        a_d        = a_q;
        b_d        = b_q;
        r_d        = r_q;
        t_d        = t_q;
        rf_we      = 1'b0;
        imem_req   = 1'b0;
        retire     = 1'b0;
        halted     = 1'b0;
        alu_opcode = 3'd0;
        case (state_q)
            FETCH: begin
                // Reset parks the FSM in FETCH, so the request is masked while rst_n is low
                imem_req = rst_n;
                if (imem_valid) begin
                    ir_d    = imem_rdata;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (opcode == OP_HALT) begin
                    state_d = HALT;
                end else begin
                    a_d     = rf_q[rs1];
                    b_d     = rf_q[rs2];
                    state_d = EXECUTE;
                end
            end
            EXECUTE: begin
                alu_opcode = opcode;
                r_d        = alu_op_0;
                t_d        = alu_change_pc;
                state_d    = WRITEBACK;
            end
            WRITEBACK: begin
                retire  = 1'b1;
                state_d = FETCH;
                if (opcode[2]) begin
                    rf_we = (rd != 3'd0);
                    pc_d  = pc_q + 32'd1;
                end else if ((opcode == OP_BEQ || opcode == OP_BLT) && t_q) begin
                    pc_d = pc_q + offset_sext;
                end else begin
                    pc_d = pc_q + 32'd1;
                end
            end
            HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            t_q     <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            t_q     <= t_d;
            if (rf_we) begin
                rf_q[rd] <= r_q;
            end
        end
    end

endmodule

// File: tb/tb_exec_sequencer.sv
// tb/tb_exec_sequencer.sv - directed vector bench for exec_sequencer
module tb_exec_sequencer;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic [31:0] alu_ip_0;
    logic [31:0] alu_ip_1;
    logic [2:0]  alu_opcode;
    logic [31:0] alu_op_0;
    logic        alu_change_pc;
    logic        retire;
    logic        halted;

    int total = 0;
    int bad   = 0;

    exec_sequencer #(.RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .imem_valid    (imem_valid),
        .alu_ip_0      (alu_ip_0),
        .alu_ip_1      (alu_ip_1),
        .alu_opcode    (alu_opcode),
        .alu_op_0      (alu_op_0),
        .alu_change_pc (alu_change_pc),
        .retire        (retire),
        .halted        (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [2:0]  op;
        logic        br;
        logic [31:0] nxt;
    } vec_t;

    vec_t vecs [21];
    vec_t v_extra;

    function automatic logic [31:0] enc(input logic [2:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs1, input logic [2:0] rs2,
                                        input logic [15:0] off);
        return {op, rd, rs1, rs2, 4'b0000, off};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called during a FETCH cycle (between edges); returns in the following FETCH cycle
    task automatic run_vec(input vec_t v);
        imem_rdata    = v.instr;
        imem_valid    = 1'b1;
        alu_op_0      = v.res;
        alu_change_pc = v.br;
        chk("fetch_req", {31'd0, imem_req}, 32'd1);
        chk("fetch_addr", imem_addr, v.pc);
        @(negedge clk);
        imem_valid = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        chk("dec_req", {31'd0, imem_req}, 32'd0);
        chk("dec_opcode", {29'd0, alu_opcode}, 32'd0);
        chk("dec_retire", {31'd0, retire}, 32'd0);
        @(negedge clk);
        chk("exe_opcode", {29'd0, alu_opcode}, {29'd0, v.op});
        chk("exe_a", alu_ip_0, v.a);
        chk("exe_b", alu_ip_1, v.b);
        chk("exe_retire", {31'd0, retire}, 32'd0);
        @(negedge clk);
        chk("wb_retire", {31'd0, retire}, 32'd1);
        chk("wb_req", {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        chk("next_addr", imem_addr, v.nxt);
        chk("next_retire", {31'd0, retire}, 32'd0);
    endtask

    initial begin
        vecs[0]  = '{32'd0,  enc(3'd4, 3'd1, 3'd0, 3'd0, 16'd0),      32'd0, 32'd0, 32'd5, 3'd4, 1'b0, 32'd1};
        vecs[1]  = '{32'd1,  enc(3'd4, 3'd2, 3'd0, 3'd0, 16'd0),      32'd0, 32'd0, 32'd3, 3'd4, 1'b0, 32'd2};
        vecs[2]  = '{32'd2,  enc(3'd5, 3'd3, 3'd1, 3'd2, 16'd0),      32'd5, 32'd3, 32'd2, 3'd5, 1'b0, 32'd3};
        vecs[3]  = '{32'd3,  enc(3'd7, 3'd4, 3'd3, 3'd1, 16'd0),      32'd2, 32'd5, 32'd7, 3'd7, 1'b0, 32'd4};
        vecs[4]  = '{32'd4,  enc(3'd4, 3'd0, 3'd1, 3'd2, 16'd0),      32'd5, 32'd3, 32'd8, 3'd4, 1'b0, 32'd5};
        vecs[5]  = '{32'd5,  enc(3'd6, 3'd5, 3'd0, 3'd4, 16'd0),      32'd0, 32'd7, 32'd0, 3'd6, 1'b0, 32'd6};
        vecs[6]  = '{32'd6,  enc(3'd0, 3'd0, 3'd0, 3'd0, 16'd0),      32'd0, 32'd0, 32'd0, 3'd0, 1'b0, 32'd7};
        vecs[7]  = '{32'd7,  enc(3'd2, 3'd0, 3'd1, 3'd2, 16'd3),      32'd5, 32'd3, 32'd0, 3'd2, 1'b0, 32'd8};
        vecs[8]  = '{32'd8,  enc(3'd2, 3'd0, 3'd0, 3'd0, 16'd2),      32'd0, 32'd0, 32'd0, 3'd2, 1'b1, 32'd10};
        vecs[9]  = '{32'd10, enc(3'd2, 3'd0, 3'd1, 3'd1, 16'hFFFE),   32'd5, 32'd5, 32'd0, 3'd2, 1'b1, 32'd8};
        vecs[10] = '{32'd8,  enc(3'd2, 3'd0, 3'd1, 3'd2, 16'd2),      32'd5, 32'd3, 32'd0, 3'd2, 1'b0, 32'd9};
        vecs[11] = '{32'd9,  enc(3'd0, 3'd0, 3'd0, 3'd0, 16'd0),      32'd0, 32'd0, 32'd0, 3'd0, 1'b0, 32'd10};
        vecs[12] = '{32'd10, enc(3'd2, 3'd0, 3'd1, 3'd2, 16'hFFFE),   32'd5, 32'd3, 32'd0, 3'd2, 1'b0, 32'd11};
        vecs[13] = '{32'd11, enc(3'd4, 3'd6, 3'd0, 3'd0, 16'd0),      32'd0, 32'd0, 32'd1, 3'd4, 1'b0, 32'd12};
        vecs[14] = '{32'd12, enc(3'd4, 3'd7, 3'd0, 3'd0, 16'd0),      32'd0, 32'd0, 32'd2, 3'd4, 1'b0, 32'd13};
        vecs[15] = '{32'd13, enc(3'd2, 3'd0, 3'd0, 3'd0, 16'd7),      32'd0, 32'd0, 32'd0, 3'd2, 1'b1, 32'd20};
        vecs[16] = '{32'd20, enc(3'd3, 3'd0, 3'd6, 3'd7, 16'd5),      32'd1, 32'd2, 32'd0, 3'd3, 1'b1, 32'd25};
        vecs[17] = '{32'd25, enc(3'd2, 3'd0, 3'd0, 3'd0, 16'hFFFB),   32'd0, 32'd0, 32'd0, 3'd2, 1'b1, 32'd20};
        vecs[18] = '{32'd20, enc(3'd3, 3'd0, 3'd7, 3'd6, 16'd5),      32'd2, 32'd1, 32'd0, 3'd3, 1'b0, 32'd21};
        vecs[19] = '{32'd21, enc(3'd2, 3'd0, 3'd0, 3'd0, 16'hFFEA),   32'd0, 32'd0, 32'd0, 3'd2, 1'b1, 32'hFFFF_FFFF};
        vecs[20] = '{32'hFFFF_FFFF, enc(3'd0, 3'd0, 3'd0, 3'd0, 16'd0), 32'd0, 32'd0, 32'd0, 3'd0, 1'b0, 32'd0};

        rst_n         = 1'b0;
        imem_valid    = 1'b0;
        imem_rdata    = '0;
        alu_op_0      = '0;
        alu_change_pc = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_retire", {31'd0, retire}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_opcode", {29'd0, alu_opcode}, 32'd0);
        chk("rst_ip0", alu_ip_0, 32'd0);
        chk("rst_ip1", alu_ip_1, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_req", {31'd0, imem_req}, 32'd1);

        for (int i = 0; i < 21; i++) begin
            run_vec(vecs[i]);
        end

        // Three FETCH wait cycles, retire lands in the 7th cycle after FETCH entry
        imem_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("wait_req", {31'd0, imem_req}, 32'd1);
            chk("wait_addr", imem_addr, 32'd0);
            @(negedge clk);
        end
        imem_rdata = enc(3'd0, 3'd0, 3'd0, 3'd0, 16'd0);
        imem_valid = 1'b1;
        @(negedge clk);
        imem_valid = 1'b0;
        chk("wait_c5_retire", {31'd0, retire}, 32'd0);
        @(negedge clk);
        chk("wait_c6_retire", {31'd0, retire}, 32'd0);
        @(negedge clk);
        chk("wait_c7_retire", {31'd0, retire}, 32'd1);
        @(negedge clk);
        chk("wait_next_addr", imem_addr, 32'd1);

        // HALT: terminal, imem_valid ignored, PC frozen
        imem_rdata = enc(3'd1, 3'd0, 3'd0, 3'd0, 16'd0);
        imem_valid = 1'b1;
        @(negedge clk);
        chk("halt_dec_halted", {31'd0, halted}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("halt_halted", {31'd0, halted}, 32'd1);
            chk("halt_req", {31'd0, imem_req}, 32'd0);
            chk("halt_retire", {31'd0, retire}, 32'd0);
            chk("halt_addr", imem_addr, 32'd1);
        end
        rst_n = 1'b0;
        imem_valid = 1'b0;
        #1;
        chk("halt_rst_halted", {31'd0, halted}, 32'd0);
        chk("halt_rst_req", {31'd0, imem_req}, 32'd0);
        chk("halt_rst_addr", imem_addr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("halt_resume_req", {31'd0, imem_req}, 32'd1);

        // Register file was cleared by reset; r2 gets 9 here
        v_extra = '{32'd0, enc(3'd7, 3'd2, 3'd1, 3'd4, 16'd0), 32'd0, 32'd0, 32'd9, 3'd7, 1'b0, 32'd1};
        run_vec(v_extra);

        // Reset in the middle of a FETCH wait
        imem_valid = 1'b0;
        @(negedge clk);
        chk("midwait_req", {31'd0, imem_req}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midwait_rst_req", {31'd0, imem_req}, 32'd0);
        chk("midwait_rst_addr", imem_addr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        v_extra = '{32'd0, enc(3'd4, 3'd1, 3'd2, 3'd2, 16'd0), 32'd0, 32'd0, 32'd0, 3'd4, 1'b0, 32'd1};
        run_vec(v_extra);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
